div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/result width (4..32).
REQ-002 SHALL have parameter SIGNED_DEF, default 1, meaning signedness used when signed_op is tied off.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only while ready=1.
REQ-006 signed_op  input  1  1 = two's-complement operation, 0 = unsigned; latched with start.
REQ-007 X  input  N  dividend; latched with start.
REQ-008 Y  input  N  divisor; latched with start.
REQ-009 ready  output  1  idle, able to accept start.
REQ-010 res  output  N  quotient, held until next completion.
REQ-011 high  output  N  remainder, held until next completion.
REQ-012 finished  output  1  one-cycle completion pulse.
REQ-013 div_zero  output  1  Y==0 on last operation; held with res.
REQ-014 ovf  output  1  signed MIN / -1 on last operation; held with res.

Function
REQ-015 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; ready=1 only in IDLE.
REQ-016 In IDLE with start=1, SHALL latch operands and mode; signed mode takes magnitudes of X and Y; next state is CALC, or DONE if Y==0.
REQ-017 CALC SHALL perform one restoring step per cycle: shift {A,Q} left, trial A-M, and keep the result with Q[0]=1 when the (N+1)-bit difference is non-negative.
REQ-018 Iteration count SHALL be N unless DIV_EARLY_TERM_EN is defined.
REQ-019 DONE SHALL register res/high/flags, pulse finished for exactly one cycle, and return to IDLE.
REQ-020 Latency SHALL be iterations+1 cycles from the start edge to finished=1 (N=16: 17 cycles); a new start is accepted in the cycle after finished.
REQ-021 Signed quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign (X = res*Y + high exactly).
REQ-022 Y==0 SHALL give res=all-ones, high=X, div_zero=1, latency 1.
REQ-023 Signed X=MIN, Y=-1 SHALL give res=MIN, high=0, ovf=1.
REQ-024 start while ready=0 SHALL be ignored, with no effect on the running operation.
REQ-025 Operand inputs SHALL be don't-care after the start edge.

Reset
REQ-026 RST_N=0 SHALL force IDLE, ready=1, finished=0, res=0, high=0, div_zero=0, ovf=0 asynchronously.
REQ-027 Reset mid-operation SHALL abandon it; no finished pulse follows deassertion.

Configuration
REQ-028 Macro DIV_EARLY_TERM_EN defined: SHALL count leading zeros of |X|, pre-shift Q by that count, and iterate max(1, N-lz) times.
REQ-029 Macro DIV_EARLY_TERM_EN undefined: SHALL use a fixed N iterations with no leading-zero logic; results are identical either way.

Structure
REQ-030 Package div_pkg SHALL hold the FSM state encoding (IDLE, CALC, DONE) and the iteration-counter width function clog2(N+1).
REQ-031 Sub-module div_lzc (parametrised leading-zero counter) SHALL be instantiated only under DIV_EARLY_TERM_EN.

Verification
REQ-032 N=16, unsigned X=100, Y=7 -> res=14, high=2, finished 17 cycles after start (macro off).
REQ-033 Signed X=-100 (0xFF9C), Y=7 -> res=0xFFF2, high=0xFFFE, div_zero=0, ovf=0.
REQ-034 Signed X=0x8000, Y=0xFFFF -> res=0x8000, high=0, ovf=1; and X=0x1234, Y=0 -> res=0xFFFF, high=0x1234, div_zero=1, latency 1.
REQ-035 start pulsed at cycle 5 of a running 1000/3 -> ignored, result 333 rem 1; RST_N low at cycle 8 of the next operation -> ready=1 immediately, no finished pulse.
REQ-036 Macro on, unsigned 5/3 -> res=1, high=2, latency 4; 0/9 -> res=0, high=0, latency 2.
REQ-037 10k random signed/unsigned pairs, both macro settings -> match the reference model bit-exactly.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding and
// the width helper used to size the iteration counter.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, at least 1; the counter uses clog2(N+1) so it can hold N.
    function automatic int clog2(input int v);
        int w;
        w = 0;
        while ((1 << w) < v) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/div_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns W.
import div_pkg::*;

module div_lzc #(
    parameter int W  = 16,
    parameter int CW = clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    // Ascending scan: the last hit is the most significant set bit.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, signed/unsigned, one quotient bit per cycle.
// Define DIV_EARLY_TERM_EN to skip the leading-zero iterations of |X|.
import div_pkg::*;

module div_iter #(
    parameter int N          = 16,
    parameter int SIGNED_DEF = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic         signed_op,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic         ready,
    output logic [N-1:0] res,
    output logic [N-1:0] high,
    output logic         finished,
    output logic         div_zero,
    output logic         ovf
);

    localparam int CW = clog2(N + 1);
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    function automatic logic [N-1:0] apply_sign(input logic [N-1:0] v, input logic neg);
        return neg ? (~v + {{(N-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          xs_q, xs_d;
    logic          ys_q, ys_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  high_q, high_d;
    logic          fin_q, fin_d;
    logic          dzo_q, dzo_d;
    logic          ovo_q, ovo_d;

    logic          x_neg, y_neg;
    logic [N-1:0]  x_abs, y_abs;
    logic [N-1:0]  q_init;
    logic [CW-1:0] iter;
    logic [N:0]    shl, diff;

    assign x_neg = signed_op & X[N-1];
    assign y_neg = signed_op & Y[N-1];
    assign x_abs = apply_sign(X, x_neg);
    assign y_abs = apply_sign(Y, y_neg);

`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0] lz;

    div_lzc #(.W(N), .CW(CW)) u_lzc (
        .din (x_abs),
        .cnt (lz)
    );

    // Leading zero quotient bits are known up front; pre-shift past them.
    assign q_init = x_abs << lz;
    assign iter   = (lz == CW'(N)) ? CW'(1) : (CW'(N) - lz);
`else
    assign q_init = x_abs;
    assign iter   = CW'(N);
`endif

    // Partial remainder stays below M, so an (N+1)-bit difference is exact.
    assign shl  = {a_q, q_q[N-1]};
    assign diff = shl - {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        x_d     = x_q;
        res_d   = res_q;
        high_d  = high_q;
        fin_d   = 1'b0;
        dzo_d   = dzo_q;
        ovo_d   = ovo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = signed_op;
                    xs_d    = x_neg;
                    ys_d    = y_neg;
                    dz_d    = (Y == '0);
                    ov_d    = signed_op && (X == MIN_V) && (Y == '1);
                    a_d     = '0;
                    q_d     = q_init;
                    m_d     = y_abs;
                    x_d     = X;
                    cnt_d   = iter;
                    state_d = (Y == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!diff[N]) begin
                    a_d = diff[N-1:0];
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    a_d = shl[N-1:0];
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                fin_d = 1'b1;
                dzo_d = dz_q;
                ovo_d = ov_q;
                if (dz_q) begin
                    res_d  = '1;
                    high_d = x_q;
                end else begin
                    // MIN / -1 falls out naturally as MIN rem 0.
                    res_d  = apply_sign(q_q, mode_q & (xs_q ^ ys_q));
                    high_d = apply_sign(a_q, mode_q & xs_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            mode_q  <= (SIGNED_DEF != 0);
            xs_q    <= 1'b0;
            ys_q    <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            high_q  <= '0;
            fin_q   <= 1'b0;
            dzo_q   <= 1'b0;
            ovo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            high_q  <= high_d;
            fin_q   <= fin_d;
            dzo_q   <= dzo_d;
            ovo_q   <= ovo_d;
        end
    end

    always_ff @(posedge CLK) begin
        a_q <= a_d;
        q_q <= q_d;
        m_q <= m_d;
        x_q <= x_d;
    end

    assign ready    = (state_q == IDLE);
    assign res      = res_q;
    assign high     = high_q;
    assign finished = fin_q;
    assign div_zero = dzo_q;
    assign ovf      = ovo_q;

endmodule
